// File: rtl/bingo_map_builder.sv
// 5x5 bingo board builder: cursor-driven placement of values 1..25 with undo and
// a one-cell-per-cycle auto-fill. The board is exported as a packed 125-bit map.
module bingo_map_builder #(
    parameter int CURSOR_WRAP  = 1,
    parameter int AUTO_FILL_EN = 1
) (
    input  logic         clk_25MHz,
    input  logic         all_rst,
    input  logic         start,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_place,
    input  logic         btn_undo,
    input  logic         auto_fill,
    output logic [124:0] map,
    output logic [2:0]   cursor_x,
    output logic [2:0]   cursor_y,
    output logic [4:0]   next_value,
    output logic         busy,
    output logic         done,
    output logic         place_err
);

    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_AUTO, S_DONE} state_t;

    state_t         r_state;
    logic [124:0]   r_map;
    logic [2:0]     r_cx;
    logic [2:0]     r_cy;
    logic [4:0]     r_next;
    logic [4:0]     r_p;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic [4:0]     r_hist [0:24];

    logic [4:0]     w_cur_idx;
    logic [4:0]     w_cur_val;
    logic [4:0]     w_p_val;
    logic [4:0]     w_undo_sel;
    logic [4:0]     w_undo_idx;
    logic           w_af;

    function automatic logic [6:0] cell_off(input logic [4:0] idx);
        return 7'(idx) * 7'd5;
    endfunction

    function automatic logic [2:0] coord_dec(input logic [2:0] v);
        if (v == 3'd0)
            return (CURSOR_WRAP != 0) ? 3'd4 : 3'd0;
        return v - 3'd1;
    endfunction

    function automatic logic [2:0] coord_inc(input logic [2:0] v);
        if (v == 3'd4)
            return (CURSOR_WRAP != 0) ? 3'd0 : 3'd4;
        return v + 3'd1;
    endfunction

    assign w_cur_idx  = 5'(r_cx) + 5'(r_cy) * 5'd5;
    assign w_cur_val  = r_map[cell_off(w_cur_idx) +: 5];
    assign w_p_val    = r_map[cell_off(r_p) +: 5];
    // Guarded so the history read index stays in range when nothing was placed.
    assign w_undo_sel = (r_next >= 5'd2) ? (r_next - 5'd2) : 5'd0;
    assign w_undo_idx = r_hist[w_undo_sel];
    assign w_af       = auto_fill && (AUTO_FILL_EN != 0);

    always_ff @(posedge clk_25MHz or posedge all_rst) begin
        if (all_rst) begin
            r_state <= S_IDLE;
            r_map   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_next  <= 5'd1;
            r_p     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < 25; i++)
                r_hist[i] <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_map   <= '0;
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_next  <= 5'd1;
                        r_done  <= 1'b0;
                        r_state <= S_EDIT;
                    end
                end
                S_EDIT: begin
                    if (btn_place) begin
                        if (w_cur_val != 5'd0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_map[cell_off(w_cur_idx) +: 5] <= r_next;
                            r_hist[r_next - 5'd1]            <= w_cur_idx;
                            r_next                           <= r_next + 5'd1;
                            if (r_next == 5'd25) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end else if (btn_undo) begin
                        if (r_next == 5'd1) begin
                            r_err <= 1'b1;
                        end else begin
                            r_map[cell_off(w_undo_idx) +: 5] <= 5'd0;
                            r_next                            <= r_next - 5'd1;
                            r_cx                              <= 3'(w_undo_idx % 5'd5);
                            r_cy                              <= 3'(w_undo_idx / 5'd5);
                        end
                    end else if (w_af) begin
                        r_p     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_AUTO;
                    end else if (btn_up) begin
                        r_cy <= coord_dec(r_cy);
                    end else if (btn_down) begin
                        r_cy <= coord_inc(r_cy);
                    end else if (btn_left) begin
                        r_cx <= coord_dec(r_cx);
                    end else if (btn_right) begin
                        r_cx <= coord_inc(r_cx);
                    end
                end
                S_AUTO: begin
                    // Each scan position costs one cycle whether or not it gets written.
                    if (w_p_val == 5'd0) begin
                        r_map[cell_off(r_p) +: 5] <= r_next;
                        r_hist[r_next - 5'd1]      <= r_p;
                        r_next                     <= r_next + 5'd1;
                    end
                    if (r_p == 5'd24) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_next  <= 5'd26;
                        r_state <= S_DONE;
                    end else begin
                        r_p <= r_p + 5'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign map        = r_map;
    assign cursor_x   = r_cx;
    assign cursor_y   = r_cy;
    assign next_value = r_next;
    assign busy       = r_busy;
    assign done       = r_done;
    assign place_err  = r_err;

endmodule

// File: tb/tb_bingo_map_builder.sv
// Scoreboard bench for bingo_map_builder: a wrapping and a saturating instance are driven
// in parallel and compared each cycle against a board-level reference model.
module tb_bingo_map_builder;

    localparam byte B_ST = 8'h80;
    localparam byte B_PL = 8'h40;
    localparam byte B_UN = 8'h20;
    localparam byte B_AF = 8'h10;
    localparam byte B_UP = 8'h08;
    localparam byte B_DN = 8'h04;
    localparam byte B_LF = 8'h02;
    localparam byte B_RT = 8'h01;

    localparam int M_IDLE = 0;
    localparam int M_EDIT = 1;
    localparam int M_AUTO = 2;
    localparam int M_FULL = 3;

    logic clk = 1'b0;
    logic all_rst = 1'b0;
    logic start = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic btn_right = 1'b0, btn_place = 1'b0, btn_undo = 1'b0, auto_fill = 1'b0;

    logic [124:0] map_w, map_s;
    logic [2:0]   cx_w, cy_w, cx_s, cy_s;
    logic [4:0]   nv_w, nv_s;
    logic         busy_w, busy_s, done_w, done_s, err_w, err_s;

    always #5 clk = ~clk;

    bingo_map_builder #(.CURSOR_WRAP(1), .AUTO_FILL_EN(1)) u_dut (
        .clk_25MHz(clk), .all_rst(all_rst), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_place(btn_place), .btn_undo(btn_undo), .auto_fill(auto_fill),
        .map(map_w), .cursor_x(cx_w), .cursor_y(cy_w), .next_value(nv_w),
        .busy(busy_w), .done(done_w), .place_err(err_w)
    );

    bingo_map_builder #(.CURSOR_WRAP(0), .AUTO_FILL_EN(1)) u_dut_sat (
        .clk_25MHz(clk), .all_rst(all_rst), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_place(btn_place), .btn_undo(btn_undo), .auto_fill(auto_fill),
        .map(map_s), .cursor_x(cx_s), .cursor_y(cy_s), .next_value(nv_s),
        .busy(busy_s), .done(done_s), .place_err(err_s)
    );

    // Reference model: index 0 wraps the cursor, index 1 saturates it.
    int m_cells [2][25];
    int m_hist  [2][25];
    int m_hcnt  [2];
    int m_cx    [2];
    int m_cy    [2];
    int m_next  [2];
    int m_mode  [2];
    int m_left  [2];
    bit m_busy  [2];
    bit m_done  [2];
    bit m_err   [2];

    logic [138:0] exp_q0 [$];
    logic [138:0] exp_q1 [$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic model_reset(input int m);
        for (int i = 0; i < 25; i++) m_cells[m][i] = 0;
        m_hcnt[m] = 0; m_cx[m] = 0; m_cy[m] = 0; m_next[m] = 1;
        m_mode[m] = M_IDLE; m_left[m] = 0;
        m_busy[m] = 0; m_done[m] = 0; m_err[m] = 0;
    endtask

    function automatic int mv(input int v, input int delta, input bit wrap);
        if (wrap) return (v + delta + 5) % 5;
        if (v + delta < 0) return 0;
        if (v + delta > 4) return 4;
        return v + delta;
    endfunction

    task automatic model_step(input int m, input byte mask);
        bit wrap;
        int idx;
        wrap = (m == 0);
        m_err[m] = 0;
        if (m_mode[m] == M_AUTO) begin
            idx = 25 - m_left[m];
            if (m_cells[m][idx] == 0) begin
                m_cells[m][idx] = m_next[m];
                m_hist[m][m_hcnt[m]] = idx;
                m_hcnt[m]++;
                m_next[m]++;
            end
            m_left[m]--;
            if (m_left[m] == 0) begin
                m_busy[m] = 0; m_done[m] = 1; m_next[m] = 26; m_mode[m] = M_FULL;
            end
        end else if (m_mode[m] == M_IDLE || m_mode[m] == M_FULL) begin
            if (mask[7]) begin
                for (int i = 0; i < 25; i++) m_cells[m][i] = 0;
                m_hcnt[m] = 0; m_cx[m] = 0; m_cy[m] = 0; m_next[m] = 1;
                m_done[m] = 0; m_mode[m] = M_EDIT;
            end
        end else begin
            idx = m_cx[m] + 5 * m_cy[m];
            if (mask[6]) begin
                if (m_cells[m][idx] != 0) m_err[m] = 1;
                else begin
                    m_cells[m][idx] = m_next[m];
                    m_hist[m][m_hcnt[m]] = idx;
                    m_hcnt[m]++;
                    m_next[m]++;
                    if (m_next[m] == 26) begin m_done[m] = 1; m_mode[m] = M_FULL; end
                end
            end else if (mask[5]) begin
                if (m_hcnt[m] == 0) m_err[m] = 1;
                else begin
                    m_hcnt[m]--;
                    idx = m_hist[m][m_hcnt[m]];
                    m_cells[m][idx] = 0;
                    m_next[m]--;
                    m_cx[m] = idx % 5;
                    m_cy[m] = idx / 5;
                end
            end else if (mask[4]) begin
                m_mode[m] = M_AUTO; m_left[m] = 25; m_busy[m] = 1;
            end else if (mask[3]) m_cy[m] = mv(m_cy[m], -1, wrap);
            else if (mask[2]) m_cy[m] = mv(m_cy[m], 1, wrap);
            else if (mask[1]) m_cx[m] = mv(m_cx[m], -1, wrap);
            else if (mask[0]) m_cx[m] = mv(m_cx[m], 1, wrap);
        end
    endtask

    function automatic logic [138:0] model_snap(input int m);
        logic [124:0] mp;
        mp = '0;
        for (int i = 0; i < 25; i++) mp[5*i +: 5] = 5'(m_cells[m][i]);
        return {mp, 3'(m_cx[m]), 3'(m_cy[m]), 5'(m_next[m]), m_busy[m], m_done[m], m_err[m]};
    endfunction

    task automatic check(input string name, input logic [138:0] act, input logic [138:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got map=%h cx=%0d cy=%0d nv=%0d busy=%b done=%b err=%b, want map=%h cx=%0d cy=%0d nv=%0d busy=%b done=%b err=%b",
                     name, $time, act[138:14], act[13:11], act[10:8], act[7:3], act[2], act[1], act[0],
                     exp[138:14], exp[13:11], exp[10:8], exp[7:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [138:0] dut_w();
        return {map_w, cx_w, cy_w, nv_w, busy_w, done_w, err_w};
    endfunction

    function automatic logic [138:0] dut_s();
        return {map_s, cx_s, cy_s, nv_s, busy_s, done_s, err_s};
    endfunction

    task automatic step(input byte mask);
        @(negedge clk);
        {start, btn_place, btn_undo, auto_fill, btn_up, btn_down, btn_left, btn_right} = mask;
        model_step(0, mask);
        model_step(1, mask);
        exp_q0.push_back(model_snap(0));
        exp_q1.push_back(model_snap(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        {start, btn_place, btn_undo, auto_fill, btn_up, btn_down, btn_left, btn_right} = 8'h00;
        #2 all_rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        check("reset_wrap", dut_w(), model_snap(0));
        check("reset_sat", dut_s(), model_snap(1));
        @(negedge clk);
        all_rst = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) check("cycle_wrap", dut_w(), exp_q0.pop_front());
            if (exp_q1.size() > 0) check("cycle_sat", dut_s(), exp_q1.pop_front());
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        byte mask;
        do_reset();

        // first place, then a rejected place on the same cell, then left at x=0
        step(B_ST);
        step(B_PL);
        step(B_PL);
        step(8'h00);
        step(B_LF);
        step(B_UN);
        step(B_UN);

        // place 1 at (2,1), 2 at (3,3), undo
        do_reset();
        step(B_ST);
        step(B_RT); step(B_RT); step(B_DN);
        step(B_PL);
        step(B_RT); step(B_DN); step(B_DN);
        step(B_PL);
        step(B_LF); step(B_UP);
        step(B_UN);
        step(B_PL | B_RT);
        step(B_UN | B_AF | B_RT);
        step(8'h00);

        // place 1 at cell 0 then auto-fill the rest, then restart from DONE
        do_reset();
        step(B_ST);
        step(B_PL);
        step(B_AF);
        for (int i = 0; i < 27; i++) step((i % 3 == 0) ? B_PL : B_RT);
        step(B_PL);
        step(B_ST);
        step(B_PL);

        // reset in the middle of auto-fill
        step(B_AF);
        for (int i = 0; i < 10; i++) step(8'h00);
        do_reset();
        step(8'h00);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                mask = 8'h00;
                if ($urandom_range(0, 9) == 0) mask |= B_ST;
                if ($urandom_range(0, 3) == 0) mask |= B_PL;
                if ($urandom_range(0, 7) == 0) mask |= B_UN;
                if ($urandom_range(0, 59) == 0) mask |= B_AF;
                if ($urandom_range(0, 2) == 0) mask |= B_UP;
                if ($urandom_range(0, 2) == 0) mask |= B_DN;
                if ($urandom_range(0, 2) == 0) mask |= B_LF;
                if ($urandom_range(0, 2) == 0) mask |= B_RT;
                step(mask);
            end
        end

        step(8'h00);
        for (int i = 0; i < 5 && (exp_q0.size() > 0 || exp_q1.size() > 0); i++) @(posedge clk);
        #2;
        if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d/%0d expected entries left, want 0", exp_q0.size(), exp_q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
